// File: rtl/event_collect16_if.sv
// event_collect16_if -- signal bundle for the event_collect16 block.
//   ev_in     : event sources, one bit per source
//   mask      : per-source enable (1 = accepted and offered)
//   pend_bus  : registered sticky pending bits
//   irq       : registered OR of (pend_bus & mask)
//   out_valid : an index is being offered
//   out_idx   : offered source index
//   out_ready : consumer accepts the offered index
//   ovf       : sticky per-source overflow flags
//   ovf_clr   : synchronous clear of all ovf bits
// Modport master is the collector side; slave is the producer/consumer side.
interface event_collect16_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
);
  logic [WIDTH-1:0] ev_in;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] pend_bus;
  logic             irq;
  logic             out_valid;
  logic [IDX_W-1:0] out_idx;
  logic             out_ready;
  logic [WIDTH-1:0] ovf;
  logic             ovf_clr;

  modport master (
    input  ev_in, mask, out_ready, ovf_clr,
    output pend_bus, irq, out_valid, out_idx, ovf
  );

  modport slave (
    output ev_in, mask, out_ready, ovf_clr,
    input  pend_bus, irq, out_valid, out_idx, ovf
  );
endinterface

// File: rtl/event_collect16.sv
// event_collect16 -- captures 16 event sources into sticky pending bits that
// feed the downstream 16-input OR stage, and serves pending sources one at a
// time in round-robin order over a valid/ready handshake. Overflow (a new
// accepted event on an already-pending source) is tracked per source.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : event_collect16_if.master (ev_in, mask, pend_bus, irq,
//           out_valid, out_idx, out_ready, ovf, ovf_clr)
// Build option:
//   EVENT_COLLECT_EDGE_EN defined   -> rising-edge event detection
//   EVENT_COLLECT_EDGE_EN undefined -> level events (every high cycle counts)
module event_collect16 #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  event_collect16_if.master bus
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] ovf_r;
  logic             irq_r;
  logic             valid_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] ptr;

  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] elig;
  logic             hs;
  logic             hit;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;

`ifdef EVENT_COLLECT_EDGE_EN
  logic [WIDTH-1:0] ev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ev_q <= '0;
    else        ev_q <= bus.ev_in;
  end

  always_comb begin
    ev = bus.ev_in & ~ev_q;
  end
`else
  always_comb begin
    ev = bus.ev_in;
  end
`endif

  always_comb begin
    acc     = ev & bus.mask;
    hs      = valid_r & bus.out_ready;
    clr_vec = '0;
    if (hs) clr_vec[idx_r] = 1'b1;
    elig    = pend & bus.mask;
  end

  // Rotating priority search starting at ptr; the 4-bit add wraps 15 -> 0.
  always_comb begin
    hit  = 1'b0;
    pick = ptr;
    cand = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cand = ptr + IDX_W'(i);
      if (!hit && elig[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend    <= '0;
      ovf_r   <= '0;
      irq_r   <= 1'b0;
      valid_r <= 1'b0;
      idx_r   <= '0;
      ptr     <= '0;
    end else begin
      // Set has priority over the handshake clear on the same bit.
      pend  <= acc | (pend & ~clr_vec);
      // A fresh overflow outranks ovf_clr on that bit.
      ovf_r <= (bus.ovf_clr ? '0 : ovf_r) | (acc & pend & ~clr_vec);
      irq_r <= |elig;
      case (state)
        IDLE: begin
          if (hit) begin
            idx_r   <= pick;
            valid_r <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (bus.out_ready) begin
            ptr     <= idx_r + IDX_W'(1);
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.pend_bus  = pend;
  assign bus.irq       = irq_r;
  assign bus.out_valid = valid_r;
  assign bus.out_idx   = idx_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_event_collect16.sv
module tb_event_collect16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  event_collect16_if bus_if ();

  event_collect16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until out_valid is seen (bounded); ok=0 if it never appears.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus_if.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.ev_in = 16'hFFFF;
    bus_if.mask = 16'hFFFF;
    bus_if.out_ready = 1'b0;
    bus_if.ovf_clr = 1'b0;
    tick();
    tick();
    checks++; if (bus_if.pend_bus !== 16'h0) begin errors++; $display("FAIL reset_pend got %h exp 0000", bus_if.pend_bus); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", bus_if.irq); end
    checks++; if (bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus_if.out_valid); end
    checks++; if (bus_if.out_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus_if.out_idx); end
    checks++; if (bus_if.ovf !== 16'h0) begin errors++; $display("FAIL reset_ovf got %h exp 0000", bus_if.ovf); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus_if.pend_bus !== 16'hFFFF) begin errors++; $display("FAIL release_pend got %h exp ffff", bus_if.pend_bus); end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL release_irq_lat got %b exp 0", bus_if.irq); end
    bus_if.ev_in = 16'h0;
    tick();
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL release_irq got %b exp 1", bus_if.irq); end
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 4'd0) begin errors++; $display("FAIL first_offer got v=%b idx=%0d exp v=1 idx=0", bus_if.out_valid, bus_if.out_idx); end
    checks++; if (bus_if.ovf !== 16'h0) begin errors++; $display("FAIL release_ovf got %h exp 0000", bus_if.ovf); end
    // Asynchronous reset in the middle of an offer.
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.out_valid !== 1'b0 || bus_if.pend_bus !== 16'h0 || bus_if.irq !== 1'b0) begin errors++; $display("FAIL async_reset got v=%b pend=%h irq=%b exp 0/0000/0", bus_if.out_valid, bus_if.pend_bus, bus_if.irq); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int got[3];
    int exp_idx[3];
    int ng;
    exp_idx = '{2, 9, 15};
    got = '{0, 0, 0};
    ng = 0;
    bus_if.out_ready = 1'b1;
    bus_if.ev_in = 16'h8204;
    tick();
    bus_if.ev_in = 16'h0;
    for (int n = 0; n < 20 && ng < 3; n++) begin
      tick();
      if (bus_if.out_valid === 1'b1) begin
        got[ng] = int'(bus_if.out_idx);
        ng++;
      end
    end
    checks++; if (ng !== 3) begin errors++; $display("FAIL rr_count got %0d exp 3", ng); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got[k] !== exp_idx[k]) begin errors++; $display("FAIL rr_idx%0d got %0d exp %0d", k, got[k], exp_idx[k]); end
    end
    tick();
    checks++; if (bus_if.pend_bus !== 16'h0 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got pend=%h v=%b exp 0000/0", bus_if.pend_bus, bus_if.out_valid); end
    checks++; if (bus_if.irq !== 1'b1) begin errors++; $display("FAIL rr_irq_hold got %b exp 1", bus_if.irq); end
    tick();
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL rr_irq_fall got %b exp 0", bus_if.irq); end
  endtask

  task automatic test_wrap();
    bit ok;
    bus_if.out_ready = 1'b1;
    bus_if.ev_in = 16'h0200;
    tick();
    bus_if.ev_in = 16'h0;
    wait_valid(ok);
    checks++; if (!ok || bus_if.out_idx !== 4'd9) begin errors++; $display("FAIL wrap_first got ok=%b idx=%0d exp 1/9", ok, bus_if.out_idx); end
    bus_if.ev_in = 16'h1008;
    tick();
    bus_if.ev_in = 16'h0;
    wait_valid(ok);
    checks++; if (!ok || bus_if.out_idx !== 4'd12) begin errors++; $display("FAIL wrap_fair got ok=%b idx=%0d exp 1/12", ok, bus_if.out_idx); end
    wait_valid(ok);
    checks++; if (!ok || bus_if.out_idx !== 4'd3) begin errors++; $display("FAIL wrap_around got ok=%b idx=%0d exp 1/3", ok, bus_if.out_idx); end
    tick();
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    bit ok;
    bus_if.out_ready = 1'b0;
    bus_if.ev_in = 16'h0010;
    tick();
    bus_if.ev_in = 16'h0;
    wait_valid(ok);
    checks++; if (!ok || bus_if.out_idx !== 4'd4) begin errors++; $display("FAIL stall_offer got ok=%b idx=%0d exp 1/4", ok, bus_if.out_idx); end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) bus_if.mask = 16'hFFEF;
      tick();
      checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 4'd4) begin errors++; $display("FAIL stall_hold%0d got v=%b idx=%0d exp 1/4", k, bus_if.out_valid, bus_if.out_idx); end
    end
    checks++; if (bus_if.irq !== 1'b0) begin errors++; $display("FAIL stall_masked_irq got %b exp 0", bus_if.irq); end
    bus_if.out_ready = 1'b1;
    tick();
    checks++; if (bus_if.pend_bus !== 16'h0 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL stall_accept got pend=%h v=%b exp 0000/0", bus_if.pend_bus, bus_if.out_valid); end
    bus_if.mask = 16'hFFFF;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_masked_drop();
    bus_if.mask = 16'hFFF7;
    bus_if.ev_in = 16'h0008;
    tick();
    bus_if.ev_in = 16'h0;
    bus_if.mask = 16'hFFFF;
    tick();
    checks++; if (bus_if.pend_bus !== 16'h0 || bus_if.irq !== 1'b0) begin errors++; $display("FAIL masked_drop got pend=%h irq=%b exp 0000/0", bus_if.pend_bus, bus_if.irq); end
  endtask

  task automatic test_overflow();
    bus_if.out_ready = 1'b0;
    bus_if.ev_in = 16'h0040;
    tick();
    bus_if.ev_in = 16'h0;
    tick();
    bus_if.ev_in = 16'h0040;
    tick();
    bus_if.ev_in = 16'h0;
    checks++; if (bus_if.ovf !== 16'h0040) begin errors++; $display("FAIL ovf_set got %h exp 0040", bus_if.ovf); end
    checks++; if (bus_if.out_valid !== 1'b1 || bus_if.out_idx !== 4'd6) begin errors++; $display("FAIL ovf_offer got v=%b idx=%0d exp 1/6", bus_if.out_valid, bus_if.out_idx); end
    tick();
    // Event on 6 in the same cycle as its handshake.
    bus_if.out_ready = 1'b1;
    bus_if.ev_in = 16'h0040;
    tick();
    bus_if.ev_in = 16'h0;
    bus_if.out_ready = 1'b0;
    checks++; if (bus_if.pend_bus !== 16'h0040 || bus_if.out_valid !== 1'b0) begin errors++; $display("FAIL collide_pend got pend=%h v=%b exp 0040/0", bus_if.pend_bus, bus_if.out_valid); end
    checks++; if (bus_if.ovf !== 16'h0040) begin errors++; $display("FAIL collide_ovf got %h exp 0040", bus_if.ovf); end
    bus_if.ovf_clr = 1'b1;
    tick();
    bus_if.ovf_clr = 1'b0;
    checks++; if (bus_if.ovf !== 16'h0) begin errors++; $display("FAIL ovf_clr got %h exp 0000", bus_if.ovf); end
    // Clear coinciding with a new overflow on 6.
    bus_if.ovf_clr = 1'b1;
    bus_if.ev_in = 16'h0040;
    tick();
    bus_if.ev_in = 16'h0;
    checks++; if (bus_if.ovf !== 16'h0040) begin errors++; $display("FAIL ovf_clr_race got %h exp 0040", bus_if.ovf); end
    tick();
    bus_if.ovf_clr = 1'b0;
    checks++; if (bus_if.ovf !== 16'h0) begin errors++; $display("FAIL ovf_clr2 got %h exp 0000", bus_if.ovf); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    checks++; if (bus_if.pend_bus !== 16'h0) begin errors++; $display("FAIL ovf_drain got %h exp 0000", bus_if.pend_bus); end
  endtask

  task automatic test_edge_level();
    logic [15:0] exp_ovf;
`ifdef EVENT_COLLECT_EDGE_EN
    exp_ovf = 16'h0000;
`else
    exp_ovf = 16'h0002;
`endif
    bus_if.out_ready = 1'b0;
    bus_if.ev_in = 16'h0002;
    for (int k = 0; k < 4; k++) tick();
    bus_if.ev_in = 16'h0;
    checks++; if (bus_if.ovf !== exp_ovf) begin errors++; $display("FAIL edge_level_ovf got %h exp %h", bus_if.ovf, exp_ovf); end
    checks++; if (bus_if.pend_bus !== 16'h0002) begin errors++; $display("FAIL edge_level_pend got %h exp 0002", bus_if.pend_bus); end
    bus_if.out_ready = 1'b1;
    tick();
    bus_if.out_ready = 1'b0;
    checks++; if (bus_if.pend_bus !== 16'h0) begin errors++; $display("FAIL edge_level_drain got %h exp 0000", bus_if.pend_bus); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.ev_in = 16'h0;
    bus_if.mask = 16'hFFFF;
    bus_if.out_ready = 1'b0;
    bus_if.ovf_clr = 1'b0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_stall();
    test_masked_drop();
    test_overflow();
    test_edge_level();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_collect16.md
Name: event_collect16

Overview:
- Sits directly upstream of the 16-input OR reduction.
- Captures 16 asynchronous-to-software event sources into sticky pending bits and drives the pending bus that the OR reduction collapses into a single "any pending" line.
- Also serves pending events one at a time, in round-robin order, over a valid/ready handshake. Overflow is tracked per source.

Parameters:
- WIDTH, 16, number of event sources; fixed at 16 to match the downstream 16-input reduction.
- IDX_W, 4, width of the served-index field (log2 WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ev_in  input  16  event sources, one bit per source.
- mask  input  16  per-source enable; 1 = events accepted and offered.
- pend_bus  output  16  registered pending bits; feeds the 16-input OR stage.
- irq  output  1  registered OR of (pend_bus & mask).
- out_valid  output  1  an index is being offered.
- out_idx  output  4  offered source index.
- out_ready  input  1  consumer accepts the offered index.
- ovf  output  16  sticky per-source overflow flags.
- ovf_clr  input  1  synchronous clear of all ovf bits.

Behaviour:
- Reset (rst_n low, asynchronous): pend_bus=0, irq=0, out_valid=0, out_idx=0, ovf=0, round-robin pointer=0, FSM=IDLE, ev_q=0.
- Event term: ev[i] is ev_in[i] or the edge term (see Optional Feature). An event is accepted only if mask[i]=1; masked events are dropped silently.
- Pending update, per bit, next cycle:
  - Set if an accepted event is present.
  - Else cleared if the handshake completes on i this cycle.
  - Else held.
- Set-and-clear collision on the same bit in the same cycle: set wins, no overflow.
- Overflow: ovf[i] is set when an accepted event arrives, pend[i] is already 1, and no clear of i occurs that cycle.
- ovf_clr clears all ovf bits. When ovf_clr coincides with a new overflow, the overflow wins, so that bit reads 1.
- irq = OR(pend & mask), registered. Latency: event at cycle t → pend at t+1 → irq at t+2.
- Masking after capture: a pend bit whose mask drops to 0 stays set but is neither offered nor counted in irq. Re-enabling the mask makes it eligible again.
- FSM state IDLE:
  - out_valid=0.
  - If (pend & mask) is nonzero, search from the pointer upward, wrapping 15→0, for the first set bit.
  - Load out_idx with that bit, assert out_valid next cycle, go to OFFER.
- FSM state OFFER:
  - out_valid=1; out_idx is held stable until accepted, even if mask or ev_in change.
  - On out_valid & out_ready: clear pend[out_idx], set pointer = out_idx+1 (mod 16), out_valid=0 next cycle, return to IDLE.
- Throughput: at most one grant per 2 cycles (one bubble in IDLE).
- Reset mid-OFFER: the offer is abandoned immediately; all state returns to reset values.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: EVENT_COLLECT_EDGE_EN.
- Defined: the event term is a rising edge, ev = ev_in & ~ev_q, with ev_q registered from ev_in (reset 0). A held-high input produces exactly one event.
- Undefined: level mode, ev = ev_in. Every cycle high is an event, so a level held for 2+ cycles while pending sets ovf. The ev_q register is absent.

Test Plan:
- Reset values: hold rst_n=0 with ev_in=16'hFFFF, mask=16'hFFFF → all outputs 0. Release reset → first pend_bus=16'hFFFF one cycle after the first clock edge.
- Round robin: mask=16'hFFFF; pulse ev_in bits 2, 9 and 15 for 1 cycle; out_ready=1 → out_idx sequence 2, 9, 15. pend_bus ends 0; irq falls 1 cycle later.
- Wrap and fairness: pointer at 10 after serving 9; pend has bits 3 and 12 → 12 served before 3; then pointer=13 → next served is 3.
- Stall: out_ready=0 for 5 cycles while offering idx 4; toggle mask[4]=0 during the stall → out_valid=1 and out_idx=4 held. Accepted when out_ready=1, pend[4] cleared.
- Overflow and collision:
  - Pend[6] set, second event on 6 → ovf=16'h0040.
  - Event on 6 in the same cycle as its handshake → pend[6]=1, ovf unchanged.
  - ovf_clr → ovf=0.
- Edge vs level: ev_in[1] held high 4 cycles with no acceptance. With EVENT_COLLECT_EDGE_EN → ovf[1]=0. Without it → ovf[1]=1.
